// File: rtl/lsu_pkg.sv
// Shared types and the request legality check for the load/store unit.
package lsu_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'd0,
        F3_H  = 3'd1,
        F3_W  = 3'd2,
        F3_BU = 3'd4,
        F3_HU = 3'd5
    } funct3_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_FAULT    = 2'd2,
        ERR_ILLEGAL  = 2'd3
    } err_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_MERGE = 2'd2
    } state_e;

    // Priority: illegal size code, then alignment, then address range.
    function automatic err_e check_req(input logic we, input logic [2:0] f3,
                                       input logic [31:0] addr, input logic [31:0] mem_size);
        logic illegal;
        logic misalign;
        illegal  = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        misalign = (f3[1:0] == 2'd1 && addr[0]) || (f3[1:0] == 2'd2 && addr[1:0] != 2'd0);
        if (illegal)
            return ERR_ILLEGAL;
        else if (misalign)
            return ERR_MISALIGN;
        else if (addr >= mem_size)
            return ERR_FAULT;
        else
            return ERR_NONE;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response and memory-side signals of the LSU; master = execute stage plus memory.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_din
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: sub-word load extract/extend and store merge into a read word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{off_i, 3'b000} +: 8];
        half_sel = word_i[{off_i[1], 4'b0000} +: 16];
        load_o   = 32'd0;
        case (funct3_i)
            F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
            F3_W:    load_o = word_i;
            F3_BU:   load_o = {24'd0, byte_sel};
            F3_HU:   load_o = {16'd0, half_sel};
            default: load_o = 32'd0;
        endcase
    end

    // A half store feeds lane gi from wdata byte (gi % 2); a byte store always from wdata[7:0].
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic       sel;
        logic [7:0] src;
        assign sel = (funct3_i[1:0] == 2'd0 && off_i == 2'(gi)) ||
                     (funct3_i[1:0] == 2'd1 && off_i[1] == 1'(gi / 2));
        assign src = (funct3_i[1:0] == 2'd1) ? wdata_i[8*(gi%2) +: 8] : wdata_i[7:0];
        assign merge_o[8*gi +: 8] = sel ? src : word_i[8*gi +: 8];
    end
endmodule

// File: rtl/lsu.sv
// Load/store unit in front of a word-wide memory without byte enables; SB/SH use read-modify-write.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned MEMORY_SIZE = 8192
) (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);
    state_e      state_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic [15:0] wdata_q;
    logic [29:0] waddr_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic [1:0]  rsp_err_q;

    err_e        req_err;
    logic        is_sw;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    assign req_err = check_req(bus.req_we, bus.req_funct3, bus.req_addr, 32'(MEMORY_SIZE));
    assign is_sw   = bus.req_we && bus.req_funct3[1:0] == 2'd2;

    lsu_align u_align (
        .word_i   (bus.mem_dout),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .wdata_i  (wdata_q),
        .load_o   (load_data),
        .merge_o  (merge_data)
    );

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // Memory strobes are gated by rst so an abandoned MERGE can never write.
    always_comb begin
        bus.mem_en   = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_addr = 32'd0;
        bus.mem_din  = 32'd0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid && req_err == ERR_NONE) begin
                        bus.mem_en   = 1'b1;
                        bus.mem_addr = {bus.req_addr[31:2], 2'b00};
                        if (is_sw) begin
                            bus.mem_we  = 1'b1;
                            bus.mem_din = bus.req_wdata;
                        end
                    end
                end
                S_MERGE: begin
                    bus.mem_en   = 1'b1;
                    bus.mem_we   = 1'b1;
                    bus.mem_addr = {waddr_q, 2'b00};
                    bus.mem_din  = merge_data;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            off_q       <= 2'd0;
            f3_q        <= 3'd0;
            wdata_q     <= 16'd0;
            waddr_q     <= 30'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 2'd0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        off_q   <= bus.req_addr[1:0];
                        f3_q    <= bus.req_funct3;
                        wdata_q <= bus.req_wdata[15:0];
                        waddr_q <= bus.req_addr[31:2];
                        if (req_err != ERR_NONE || is_sw) begin
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= 32'd0;
                            rsp_err_q   <= req_err;
                        end else if (!bus.req_we) begin
                            state_q <= S_LOAD;
                        end else begin
                            state_q <= S_MERGE;
                        end
                    end
                end
                S_LOAD: begin
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= load_data;
                    rsp_err_q   <= ERR_NONE;
                    state_q     <= S_IDLE;
                end
                S_MERGE: begin
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= 32'd0;
                    rsp_err_q   <= ERR_NONE;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
